// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared LED block types, pattern codes and arbitration helper
package led_pkg;

  localparam int NREQ    = 4;
  localparam int PHASE_W = 6;
  localparam int HOLD_W  = 8;

  typedef enum logic [1:0] {
    PAT_SOLID  = 2'b00,
    PAT_SLOW   = 2'b01,
    PAT_FAST   = 2'b10,
    PAT_DOUBLE = 2'b11
  } pat_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SERVE = 1'b1
  } state_e;

  // First set request at or after ptr, walking the requesters circularly.
  function automatic logic [1:0] rr_pick(input logic [NREQ-1:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    rr_pick = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/led_sequencer_if.sv
// rtl/led_sequencer_if.sv - request/pattern in, grant/led/busy out bundle
interface led_sequencer_if;

  logic [led_pkg::NREQ-1:0]   req;
  logic [2*led_pkg::NREQ-1:0] pat;
  logic [led_pkg::NREQ-1:0]   grant;
  logic                       led;
  logic                       busy;

  modport master (
    output req,
    output pat,
    input  grant,
    input  led,
    input  busy
  );

  modport slave (
    input  req,
    input  pat,
    output grant,
    output led,
    output busy
  );

endinterface

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - free-running prescaler emitting a one-cycle tick every TICK_DIV clocks
module led_tick_gen #(
  parameter int TICK_DIV = 480000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - round-robin LED arbiter with minimum hold and per-owner blink pattern
module led_sequencer
  import led_pkg::*;
#(
  parameter int TICK_DIV = 480000,
  parameter int MIN_HOLD = 50
) (
  input  logic             clk,
  input  logic             rst,
  led_sequencer_if.slave   bus
);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD);

  state_e              state_q, state_d;
  logic [NREQ-1:0]     grant_q, grant_d;
  logic [1:0]          gidx_q, gidx_d;
  logic [1:0]          rr_q, rr_d;
  pat_e                pat_q, pat_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;

  logic       tick;
  logic       hold_done;
  logic       own_req;
  logic       other_req;
  logic       release_now;
  logic [1:0] sel;
  logic       led_on;

  // Prescaler sits at zero while idle so every grant starts a fresh tick period.
  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q == ST_IDLE),
    .tick (tick)
  );

  assign hold_done   = (hold_q == HOLD_MAX);
  assign own_req     = |(bus.req & grant_q);
  assign other_req   = |(bus.req & ~grant_q);
  assign release_now = hold_done &&
                       (!own_req || (tick && (phase_q == '1) && other_req));

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    rr_d    = rr_q;
    pat_d   = pat_q;
    phase_d = phase_q;
    hold_d  = hold_q;
    sel     = rr_pick(bus.req, rr_q);
    case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          state_d = ST_SERVE;
          grant_d = NREQ'(1) << sel;
          gidx_d  = sel;
          pat_d   = pat_e'(bus.pat[{sel, 1'b0} +: 2]);
          phase_d = '0;
          hold_d  = '0;
        end
      end
      ST_SERVE: begin
        if (tick) begin
          phase_d = phase_q + PHASE_W'(1);
          if (!hold_done) hold_d = hold_q + HOLD_W'(1);
        end
        if (release_now) begin
          state_d = ST_IDLE;
          grant_d = '0;
          rr_d    = gidx_q + 2'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      rr_q    <= '0;
      pat_q   <= PAT_SOLID;
      phase_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      rr_q    <= rr_d;
      pat_q   <= pat_d;
      phase_q <= phase_d;
      hold_q  <= hold_d;
    end
  end

  // Double blink: on for phases 0..3 and 8..11 of each 64-tick frame.
  always_comb begin
    led_on = 1'b0;
    if (state_q == ST_SERVE) begin
      case (pat_q)
        PAT_SOLID:  led_on = 1'b1;
        PAT_SLOW:   led_on = ~phase_q[5];
        PAT_FAST:   led_on = ~phase_q[3];
        PAT_DOUBLE: led_on = (phase_q[5:4] == 2'b00) && !phase_q[2];
        default:    led_on = 1'b0;
      endcase
    end
  end

  assign bus.grant = grant_q;
  assign bus.busy  = (state_q == ST_SERVE);
  assign bus.led   = led_on;

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 480000, meaning clk cycles per pattern tick (10 ms at 48 MHz; legal range 2..2^20).
REQ-002 SHALL have parameter MIN_HOLD, default 50, meaning the minimum number of ticks a grant is held (legal range 1..255).
REQ-003 SHALL have port clk, input, 1 bit: the single clock, driven from the internal HF oscillator.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port req, input, 4 bits: per-requester LED request, level-sensitive.
REQ-006 SHALL have port pat, input, 8 bits: 2-bit pattern code per requester, with requester i at bits [2i+1:2i].
REQ-007 SHALL have port grant, output, 4 bits: one-hot owner of the LED, or all-zero.
REQ-008 SHALL have port led, output, 1 bit: LED drive, active-high.
REQ-009 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-010 SHALL generate a one-cycle tick when the prescaler equals TICK_DIV-1; the prescaler then wraps to 0.
REQ-011 SHALL keep a 6-bit phase that increments modulo 64 on each tick while the state is SERVE, giving a frame of 64 ticks.
REQ-012 SHALL decode led combinationally from registered state, phase and latched pattern: 00 solid on; 01 on when phase 0..31; 10 on when phase[3]==0; 11 on when phase in 0..3 or 8..11.
REQ-013 SHALL implement the states IDLE and SERVE; in IDLE, grant=0 and led=0.
REQ-014 SHALL, in IDLE with req!=0, select the first set req bit at or after rr_ptr (circular order); on the next cycle, state=SERVE, grant=one-hot(selection), pattern latched from pat, and phase, hold and prescaler all cleared.
REQ-015 SHALL, in SERVE, ignore changes to pat; the latched pattern is used until release.
REQ-016 SHALL increment the hold counter on each tick in SERVE, saturating at MIN_HOLD; hold_done is defined as hold==MIN_HOLD.
REQ-017 SHALL evaluate release each cycle in SERVE: release when hold_done and either req[g]==0, or (tick and phase==63 and some other req bit is set).
REQ-018 SHALL keep grant and led active when req[g] drops before hold_done, until the release condition is met.
REQ-019 SHALL, on release, go to IDLE on the next cycle with rr_ptr=(g+1) mod 4; IDLE lasts at least one cycle before any re-grant.
REQ-020 SHALL not rotate the grant when no other requester is pending; the current grant is held indefinitely and phase keeps wrapping.
REQ-021 SHALL give a simultaneous req rise and release no special priority; re-arbitration happens in IDLE only.
REQ-022 SHALL keep grant one-hot or zero at all times.

Reset
REQ-023 SHALL, while rst is high, asynchronously force state=IDLE, rr_ptr=0, prescaler=0, phase=0, hold=0, latched pattern=00, grant=0, led=0, busy=0.
REQ-024 SHALL, on rst asserted mid-SERVE, drop grant and led in the same cycle; the first grant after rst deasserts is re-arbitrated from rr_ptr=0.

Structure
REQ-025 SHALL place pattern-code constants (PAT_SOLID, PAT_SLOW, PAT_FAST, PAT_DOUBLE), state encodings and NREQ=4 in a shared package, led_pkg.
REQ-026 SHALL implement the prescaler as a sub-module, led_tick_gen (inputs clk, rst, clr; output tick), reusable by other LED blocks.
REQ-027 SHALL keep the arbiter, hold/phase counters and pattern decode in led_sequencer.

Verification (TICK_DIV=4, MIN_HOLD=8)
REQ-028 SHALL cover: req=0001, pat[1:0]=01, held high -> grant=0001 one cycle later; led high for 128 cycles, then low for 128 cycles, repeating; busy=1.
REQ-029 SHALL cover: one-cycle pulse on req[1] from IDLE -> grant=0010 held exactly 33 cycles, then IDLE for at least one cycle.
REQ-030 SHALL cover: req=0101 held from reset -> grant=0001 held exactly 256 cycles, then one IDLE cycle, then grant=0100 with phase=0.
REQ-031 SHALL cover: pat changed from 00 to 10 during SERVE -> led stays solid on until release.
REQ-032 SHALL cover: rst pulsed 100 cycles into a grant to requester 2 -> grant and led are 0 asynchronously; after rst deasserts with req=0101, grant=0001.
REQ-033 SHALL cover: req=1111 held -> grants cycle 0001, 0010, 0100, 1000, 0001, each held 256 cycles.
